// File: rtl/sfft_peak_finder.sv
// rtl/sfft_peak_finder.sv - per-band spectral peak finder with a double-buffered peak table
// Scans the lower half of each new SFFT spectrum and publishes one max-magnitude bin per band.
module sfft_peak_finder #(
  parameter int NFFT       = 512,
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_BANDS  = 8,
  parameter int TIME_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sfft_valid_i,
  output logic [$clog2(NFFT)-1:0]       bin_addr_o,
  input  logic signed [BIN_WIDTH-1:0]   bin_data_i,
  input  logic                          rd_busy_i,
  input  logic [$clog2(NUM_BANDS)-1:0]  rd_band_i,
  output logic [$clog2(NFFT)-2:0]       rd_bin_o,
  output logic [BIN_WIDTH-1:0]          rd_mag_o,
  output logic [TIME_WIDTH-1:0]         frame_count_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overrun_o
);

  localparam int AW       = $clog2(NFFT);
  localparam int BW       = AW - 1;
  localparam int BANDW    = $clog2(NUM_BANDS);
  localparam int BAND     = NFFT / (2 * NUM_BANDS);
  localparam int LOG_BAND = $clog2(BAND);

  localparam logic [AW-1:0]        LAST_ADDR = AW'(NFFT / 2 - 1);
  localparam logic [BW-1:0]        BAND_MASK = BW'(BAND - 1);
  localparam logic [BIN_WIDTH-1:0] MAG_MAX   = {1'b0, {(BIN_WIDTH-1){1'b1}}};
  localparam logic [BIN_WIDTH-1:0] MOST_NEG  = {1'b1, {(BIN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   sv_q;
  logic [AW-1:0]          bin_addr_q;
  logic                   cons_valid_q;
  logic [BW-1:0]          cons_bin_q;
  logic [BIN_WIDTH-1:0]   run_mag_q;
  logic [BW-1:0]          run_bin_q;
  logic                   pub_sel_q;
  logic [BW-1:0]          bank_bin_q [2][NUM_BANDS];
  logic [BIN_WIDTH-1:0]   bank_mag_q [2][NUM_BANDS];
  logic [TIME_WIDTH-1:0]  frame_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overrun_q;

  logic                   start_d;
  logic                   band_start_d;
  logic                   band_last_d;
  logic [BANDW-1:0]       band_idx_d;
  logic [BIN_WIDTH-1:0]   mag_d;
  logic [BIN_WIDTH-1:0]   run_mag_d;
  logic [BW-1:0]          run_bin_d;

  assign start_d      = sfft_valid_i & ~sv_q;
  assign band_start_d = (cons_bin_q & BAND_MASK) == '0;
  assign band_last_d  = (cons_bin_q & BAND_MASK) == BAND_MASK;
  assign band_idx_d   = cons_bin_q[BW-1:LOG_BAND];

  // The most negative word has no positive counterpart, so it clamps to the largest magnitude.
  always_comb begin
    mag_d = $unsigned(bin_data_i);
    if (bin_data_i[BIN_WIDTH-1]) begin
      if ($unsigned(bin_data_i) == MOST_NEG) begin
        mag_d = MAG_MAX;
      end else begin
        mag_d = $unsigned(-bin_data_i);
      end
    end
    if (cons_bin_q == '0) begin
      mag_d = '0;
    end
  end

  // A band restarts at (0, first bin); only a strictly larger magnitude moves the peak.
  always_comb begin
    run_mag_d = run_mag_q;
    run_bin_d = run_bin_q;
    if (band_start_d || (mag_d > run_mag_q)) begin
      run_mag_d = mag_d;
      run_bin_d = cons_bin_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sv_q         <= 1'b0;
      bin_addr_q   <= '0;
      cons_valid_q <= 1'b0;
      cons_bin_q   <= '0;
      run_mag_q    <= '0;
      run_bin_q    <= '0;
      pub_sel_q    <= 1'b0;
      frame_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          bank_bin_q[s][b] <= '0;
          bank_mag_q[s][b] <= '0;
        end
      end
    end else begin
      sv_q         <= sfft_valid_i;
      done_q       <= 1'b0;
      cons_valid_q <= 1'b0;

      if (cons_valid_q) begin
        run_mag_q <= run_mag_d;
        run_bin_q <= run_bin_d;
        if (band_last_d) begin
          bank_bin_q[~pub_sel_q][band_idx_d] <= run_bin_d;
          bank_mag_q[~pub_sel_q][band_idx_d] <= run_mag_d;
        end
      end

      if (start_d && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q    <= SCAN;
            bin_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          cons_valid_q <= 1'b1;
          cons_bin_q   <= bin_addr_q[BW-1:0];
          if (bin_addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
          end else begin
            bin_addr_q <= bin_addr_q + AW'(1);
          end
        end
        DRAIN: begin
          state_q <= PUBLISH;
        end
        PUBLISH: begin
          // The bank swap waits for the host so a readout never straddles two frames.
          if (!rd_busy_i) begin
            pub_sel_q  <= ~pub_sel_q;
            frame_q    <= frame_q + TIME_WIDTH'(1);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            bin_addr_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bin_addr_o    = bin_addr_q;
  assign rd_bin_o      = bank_bin_q[pub_sel_q][rd_band_i];
  assign rd_mag_o      = bank_mag_q[pub_sel_q][rd_band_i];
  assign frame_count_o = frame_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;

endmodule
